// File: rtl/stream_mux_n_1.sv
// N-to-1 valid/ready stream multiplexer with a one-entry registered output.
// The channel is chosen by SEL (MODE=0) or by round-robin (MODE=1).
// Define MUX_PACKET_LOCK_EN to add IN_LAST/OUT_LAST and packet-locked round-robin.
module stream_mux_n_1 #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                             CLOCK_50,
    input  logic                             RESET_InHigh,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] IN_DATA,
    input  logic [NUM_INPUTS-1:0]            IN_VALID,
    output logic [NUM_INPUTS-1:0]            IN_READY,
`ifdef MUX_PACKET_LOCK_EN
    input  logic [NUM_INPUTS-1:0]            IN_LAST,
    output logic                             OUT_LAST,
`endif
    input  logic                             MODE,
    input  logic [SEL_WIDTH-1:0]             SEL,
    output logic [DATA_WIDTH-1:0]            OUT_DATA,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [SEL_WIDTH-1:0]             OUT_CHANNEL
);

    localparam int NUM_SLOTS = 2 ** SEL_WIDTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [SEL_WIDTH-1:0]    out_channel_reg;
    logic [SEL_WIDTH-1:0]    ptr_reg;
    logic [DATA_WIDTH-1:0]   chan_data [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    chan_valid;
    logic                    grant_valid;
    logic [SEL_WIDTH-1:0]    grant_ch;
    logic                    can_load;
    logic                    xfer_in;
    logic                    xfer_out;
    int                      rr_idx;
`ifdef MUX_PACKET_LOCK_EN
    logic [NUM_SLOTS-1:0]    chan_last;
    logic                    lock_reg;
    logic                    out_last_reg;
`endif

    // Spread channels over the full index space so any SEL value indexes safely.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi = gi + 1) begin : g_slot
            if (gi < NUM_INPUTS) begin : g_real
                assign chan_data[gi]  = IN_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
                assign chan_valid[gi] = IN_VALID[gi];
`ifdef MUX_PACKET_LOCK_EN
                assign chan_last[gi]  = IN_LAST[gi];
`endif
            end else begin : g_pad
                assign chan_data[gi]  = '0;
                assign chan_valid[gi] = 1'b0;
`ifdef MUX_PACKET_LOCK_EN
                assign chan_last[gi]  = 1'b0;
`endif
            end
        end
    endgenerate

    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        rr_idx      = 0;
        if (!MODE) begin
            if (int'(SEL) < NUM_INPUTS) begin
                grant_valid = 1'b1;
                grant_ch    = SEL;
            end
`ifdef MUX_PACKET_LOCK_EN
        end else if (lock_reg) begin
            grant_valid = 1'b1;
            grant_ch    = ptr_reg;
`endif
        end else begin
            // Search starts just after the last granted channel, wrapping around.
            for (int i = 1; i <= NUM_INPUTS; i++) begin
                rr_idx = (int'(ptr_reg) + i) % NUM_INPUTS;
                if (!grant_valid && chan_valid[SEL_WIDTH'(rr_idx)]) begin
                    grant_valid = 1'b1;
                    grant_ch    = SEL_WIDTH'(rr_idx);
                end
            end
        end
    end

    assign can_load = (state_reg == ST_EMPTY) || OUT_READY;
    assign xfer_in  = grant_valid && can_load && chan_valid[grant_ch];
    assign xfer_out = (state_reg == ST_FULL) && OUT_READY;

    generate
        for (gi = 0; gi < NUM_INPUTS; gi = gi + 1) begin : g_ready
            assign IN_READY[gi] = !RESET_InHigh && can_load && grant_valid
                                  && (grant_ch == SEL_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (xfer_in) state_next = ST_FULL;
            ST_FULL:  if (xfer_out && !xfer_in) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            out_data_reg    <= '0;
            out_channel_reg <= '0;
            ptr_reg         <= SEL_WIDTH'(NUM_INPUTS - 1);
`ifdef MUX_PACKET_LOCK_EN
            lock_reg        <= 1'b0;
            out_last_reg    <= 1'b0;
`endif
        end else if (xfer_in) begin
            out_data_reg    <= chan_data[grant_ch];
            out_channel_reg <= grant_ch;
            if (MODE) begin
                ptr_reg <= grant_ch;
`ifdef MUX_PACKET_LOCK_EN
                lock_reg <= !chan_last[grant_ch];
`endif
            end
`ifdef MUX_PACKET_LOCK_EN
            out_last_reg <= chan_last[grant_ch];
`endif
        end
    end

    assign OUT_DATA    = out_data_reg;
    assign OUT_VALID   = (state_reg == ST_FULL);
    assign OUT_CHANNEL = out_channel_reg;
`ifdef MUX_PACKET_LOCK_EN
    assign OUT_LAST    = out_last_reg;
`endif

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Directed-vector bench for stream_mux_n_1 (default 4-channel build plus a 6-channel instance).
// Packet-lock sequence runs only when MUX_PACKET_LOCK_EN is defined.
module tb_stream_mux_n_1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = 32'h44332211;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_channel;

    logic [47:0] in_data6 = 48'h665544332211;
    logic [5:0]  in_valid6 = 6'h3F;
    logic [5:0]  in_ready6;
    logic [2:0]  sel6 = '0;
    logic [7:0]  out_data6;
    logic        out_valid6;
    logic        out_ready6 = 1'b1;
    logic [2:0]  out_channel6;
`ifdef MUX_PACKET_LOCK_EN
    logic [3:0]  in_last = '0;
    logic        out_last;
    logic [5:0]  in_last6 = '0;
    logic        out_last6;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_mux_n_1 #(.DATA_WIDTH(8), .NUM_INPUTS(4), .SEL_WIDTH(2)) dut (
        .CLOCK_50(clk), .RESET_InHigh(rst),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
`ifdef MUX_PACKET_LOCK_EN
        .IN_LAST(in_last), .OUT_LAST(out_last),
`endif
        .MODE(mode), .SEL(sel),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_CHANNEL(out_channel)
    );

    stream_mux_n_1 #(.DATA_WIDTH(8), .NUM_INPUTS(6), .SEL_WIDTH(3)) dut6 (
        .CLOCK_50(clk), .RESET_InHigh(rst),
        .IN_DATA(in_data6), .IN_VALID(in_valid6), .IN_READY(in_ready6),
`ifdef MUX_PACKET_LOCK_EN
        .IN_LAST(in_last6), .OUT_LAST(out_last6),
`endif
        .MODE(1'b0), .SEL(sel6),
        .OUT_DATA(out_data6), .OUT_VALID(out_valid6), .OUT_READY(out_ready6),
        .OUT_CHANNEL(out_channel6)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        // Fixed select, then round-robin wrap, sparse RR, backpressure, RR idle.
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        vecs[1]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h33, 2'd2};
        vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[11] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[12] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[13] = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[14] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[15] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[16] = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[17] = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[18] = '{1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        vecs[19] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h22, 2'd1};
        vecs[20] = '{1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h22, 2'd1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_channel", 32'(out_channel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 21; v++) begin
            @(negedge clk);
            mode = vecs[v].mode;
            sel = vecs[v].sel;
            in_valid = vecs[v].valid;
            out_ready = vecs[v].ordy;
            #1;
            check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            check($sformatf("v%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_od));
            check($sformatf("v%0d_out_channel", v), 32'(out_channel), 32'(vecs[v].exp_ch));
            $display("vec %0d mode=%0d sel=%0d valid=%b ready=%b -> ov=%0d data=%h ch=%0d",
                     v, mode, sel, in_valid, in_ready, out_valid, out_data, out_channel);
        end

        // Six-channel instance: last real channel selectable, out-of-range SEL grants nothing.
        @(negedge clk);
        sel6 = 3'd5;
        #1;
        check("n6_sel5_ready", 32'(in_ready6), 32'h20);
        @(posedge clk);
        #1;
        check("n6_sel5_valid", 32'(out_valid6), 32'd1);
        check("n6_sel5_data", 32'(out_data6), 32'h66);
        check("n6_sel5_channel", 32'(out_channel6), 32'd5);
        $display("n6 sel=5 -> ov=%0d data=%h ch=%0d", out_valid6, out_data6, out_channel6);
        @(negedge clk);
        sel6 = 3'd7;
        #1;
        check("n6_sel7_ready", 32'(in_ready6), 32'd0);
        @(posedge clk);
        #1;
        check("n6_sel7_valid", 32'(out_valid6), 32'd0);
        $display("n6 sel=7 -> ov=%0d", out_valid6);
        @(negedge clk);
        sel6 = 3'd6;
        #1;
        check("n6_sel6_ready", 32'(in_ready6), 32'd0);

        // Reset arriving while FULL discards the held word immediately.
        @(negedge clk);
        in_data = 32'h445A2211;
        mode = 1'b0;
        sel = 2'd2;
        in_valid = 4'b0100;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_data", 32'(out_data), 32'h5A);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_channel", 32'(out_channel), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        $display("mid-reset -> ov=%0d data=%h ch=%0d ready=%b", out_valid, out_data, out_channel, in_ready);
        @(negedge clk);
        rst = 1'b0;
        in_data = 32'h44332211;
        mode = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("post_rst_rr_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("post_rst_rr_channel", 32'(out_channel), 32'd0);
        check("post_rst_rr_data", 32'(out_data), 32'h11);
        $display("post-reset rr -> ch=%0d data=%h", out_channel, out_data);

`ifdef MUX_PACKET_LOCK_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1;
        out_ready = 1'b1;
        in_valid = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            logic [1:0] exp_ch;
            logic       exp_last;
            exp_ch = (b == 3) ? 2'd1 : 2'd0;
            exp_last = (b == 2);
            in_last = (b == 2) ? 4'b0001 : 4'b0000;
            @(posedge clk);
            #1;
            check($sformatf("lock_b%0d_channel", b), 32'(out_channel), 32'(exp_ch));
            check($sformatf("lock_b%0d_last", b), 32'(out_last), 32'(exp_last));
            $display("lock beat %0d -> ch=%0d last=%0d", b, out_channel, out_last);
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
